// File: rtl/max_min_sequencer.sv
// Frame max/min tracker: collects up to 32 signed samples, reports value+index.
// Define MAXMIN_SEQ_ABS_EN to rank samples by magnitude instead of signed value.
module max_min_sequencer (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         frame_len,
    input  logic               in_valid,
    input  logic signed [7:0]  in_data,
    output logic               in_ready,
    input  logic               out_ready,
    output logic               out_valid,
    output logic signed [12:0] out_max,
    output logic signed [12:0] out_min,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [5:0]  len_q;
    logic [5:0]  eff_len;
    logic        accept;
    logic        last;
    logic        max_lt;
    logic        min_lt;
    logic [12:0] max_q;
    logic [12:0] min_q;

`ifdef MAXMIN_SEQ_ABS_EN
    // 9 bits so that |-128| = 128 is representable
    function automatic logic [8:0] mag(input logic [7:0] v);
        logic [8:0] ext;
        ext = {v[7], v};
        return v[7] ? (~ext + 9'd1) : ext;
    endfunction

    function automatic logic lt(input logic [7:0] a, input logic [7:0] b);
        return mag(a) < mag(b);
    endfunction
`else
    function automatic logic lt(input logic [7:0] a, input logic [7:0] b);
        return $signed(a) < $signed(b);
    endfunction
`endif

    always_comb begin
        eff_len = frame_len;
        if (frame_len == 6'd0 || frame_len > 6'd32)
            eff_len = 6'd32;
    end

    assign accept = in_valid && in_ready;
    assign last   = accept && ({1'b0, cnt} == (len_q - 6'd1));
    assign max_lt = lt(max_q[12:5], in_data);
    assign min_lt = lt(min_q[12:5], in_data);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: ;
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // First sample seeds both trackers; ties keep old max, take new min
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 5'd0;
            len_q <= 6'd0;
            max_q <= 13'd0;
            min_q <= 13'd0;
        end else begin
            if (state == IDLE && start) begin
                len_q <= eff_len;
                cnt   <= 5'd0;
            end
            if (accept) begin
                if (!last)
                    cnt <= cnt + 5'd1;
                if (cnt == 5'd0) begin
                    max_q <= {in_data, cnt};
                    min_q <= {in_data, cnt};
                end else begin
                    if (max_lt)
                        max_q <= {in_data, cnt};
                    if (!min_lt)
                        min_q <= {in_data, cnt};
                end
            end
        end
    end

    assign out_max = max_q;
    assign out_min = min_q;

endmodule

// File: tb/tb_max_min_sequencer.sv
// Directed self-checking bench for max_min_sequencer.
// Expected results are hand-computed value/index pairs.
module tb_max_min_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [5:0]         frame_len;
    logic               in_valid;
    logic signed [7:0]  in_data;
    logic               in_ready;
    logic               out_ready;
    logic               out_valid;
    logic signed [12:0] out_max;
    logic signed [12:0] out_min;
    logic               busy;

    int checks = 0;
    int errors = 0;

    max_min_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_max   (out_max),
        .out_min   (out_min),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [12:0] obs,
                         input logic [12:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] pack(input int v, input int i);
        logic [7:0] vb;
        logic [4:0] ib;
        vb = v[7:0];
        ib = i[4:0];
        return {vb, ib};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len);
        start     = 1'b1;
        frame_len = len[5:0];
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = v[7:0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", {12'd0, out_valid}, 13'd0);
        check("release_busy", {12'd0, busy}, 13'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        frame_len = 6'd0;
        in_valid  = 1'b0;
        in_data   = 8'sd0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", {12'd0, out_valid}, 13'd0);
        check("rst_ready", {12'd0, in_ready}, 13'd0);
        check("rst_busy", {12'd0, busy}, 13'd0);
        check("rst_max", out_max, 13'd0);
        check("rst_min", out_min, 13'd0);

        // Basic frame, no gaps
        start_frame(4);
        check("f1_ready", {12'd0, in_ready}, 13'd1);
        check("f1_busy", {12'd0, busy}, 13'd1);
        send(5);
        send(-3);
        send(12);
        check("f1_early", {12'd0, out_valid}, 13'd0);
        send(0);
        check("f1_valid", {12'd0, out_valid}, 13'd1);
        check("f1_max", out_max, pack(12, 2));
        check("f1_min", out_min, pack(-3, 1));
        release_result();

        // Ties, with in_valid gaps
        start_frame(3);
        send(7);
        tick();
        tick();
        check("f2_gap_busy", {12'd0, busy}, 13'd1);
        send(7);
        tick();
        send(7);
        check("f2_valid", {12'd0, out_valid}, 13'd1);
        check("f2_max", out_max, pack(7, 0));
        check("f2_min", out_min, pack(7, 2));
        release_result();

        // Length 0 means 32; hold in DONE
        start_frame(0);
        for (int i = 0; i < 31; i++) send(i);
        check("f3_early", {12'd0, out_valid}, 13'd0);
        send(31);
        for (int i = 0; i < 5; i++) begin
            check("f3_hold_valid", {12'd0, out_valid}, 13'd1);
            check("f3_hold_max", out_max, pack(31, 31));
            check("f3_hold_min", out_min, pack(0, 0));
            tick();
        end
        // start with out_ready only returns to IDLE
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("f3_idle_busy", {12'd0, busy}, 13'd0);
        tick();
        check("f3_no_restart", {12'd0, busy}, 13'd0);

        // Reset mid-frame discards it
        start_frame(4);
        send(40);
        send(-40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("f4_rst_busy", {12'd0, busy}, 13'd0);
        check("f4_rst_valid", {12'd0, out_valid}, 13'd0);
        check("f4_rst_max", out_max, 13'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("f4_no_pulse", {12'd0, out_valid}, 13'd0);
        end
        start_frame(1);
        send(-128);
        check("f4_valid", {12'd0, out_valid}, 13'd1);
        check("f4_max", out_max, pack(-128, 0));
        check("f4_min", out_min, pack(-128, 0));
        release_result();

        // Disturbances: in_valid in IDLE/DONE, start in COLLECT
        in_valid = 1'b1;
        in_data  = 8'sd100;
        tick();
        in_valid = 1'b0;
        check("f5_idle_busy", {12'd0, busy}, 13'd0);
        start_frame(3);
        send(1);
        start     = 1'b1;
        frame_len = 6'd1;
        send(9);
        start = 1'b0;
        check("f5_not_done", {12'd0, out_valid}, 13'd0);
        send(-5);
        check("f5_valid", {12'd0, out_valid}, 13'd1);
        in_valid = 1'b1;
        in_data  = 8'sd127;
        tick();
        in_valid = 1'b0;
        check("f5_max", out_max, pack(9, 1));
        check("f5_min", out_min, pack(-5, 2));
        check("f5_still_valid", {12'd0, out_valid}, 13'd1);
        release_result();

        // Length above 32 clamps to 32
        start_frame(45);
        for (int i = 0; i < 31; i++) send(31 - i);
        check("f6_early", {12'd0, out_valid}, 13'd0);
        send(0);
        check("f6_valid", {12'd0, out_valid}, 13'd1);
        check("f6_max", out_max, pack(31, 0));
        check("f6_min", out_min, pack(0, 31));
        release_result();

        // Signed vs magnitude ranking
        start_frame(3);
        send(-100);
        send(50);
        send(-128);
        check("f7_valid", {12'd0, out_valid}, 13'd1);
`ifdef MAXMIN_SEQ_ABS_EN
        check("f7_max", out_max, pack(-128, 2));
        check("f7_min", out_min, pack(50, 1));
`else
        check("f7_max", out_max, pack(50, 1));
        check("f7_min", out_min, pack(-128, 2));
`endif
        release_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
